// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: grant encodings and response-buffer depth shared by bram_sp_arbiter and bram_rsp_buf
package bram_arb_pkg;
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_WR = 2'd1;
    localparam logic [1:0] GNT_RD = 2'd2;
    localparam int RSP_DEPTH = 2;
endpackage

// File: rtl/bram_rsp_buf.sv
// bram_rsp_buf: 2-entry FIFO holding read responses until the consumer accepts them
// Ports: clk, rst (sync, active-high); push/push_data write the tail entry;
// pop retires the head entry; count is the occupancy; head_data is the head entry.
// Reset clears pointers, occupancy and stored data, so head_data reads 0 afterwards.
module bram_rsp_buf
    import bram_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [DW-1:0] head_data
);
    logic [DW-1:0] mem [RSP_DEPTH];
    logic head, tail;
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            head <= 1'b0;
            tail <= 1'b0;
            for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail <= ~tail;
            end
            if (pop) head <= ~head;
            count <= count + 2'(push) - 2'(pop);
        end
    end
    assign head_data = mem[head];
endmodule

// File: rtl/bram_sp_arbiter.sv
// bram_sp_arbiter: arbitrates a write and a read request channel onto one single-port BRAM
// Ports: clk, rst (sync, active-high);
//   wr_req_valid/ready/addr/data - write requests;
//   rd_req_valid/ready/addr     - read requests;
//   rd_rsp_valid/ready/data     - read responses, in read-issue order;
//   ram_wr/ram_addr/ram_data_in/ram_data_out - BRAM port (1-cycle registered read).
// Build option: define BRAM_ARB_RR_EN for round-robin contention; otherwise writes win.
module bram_sp_arbiter
    import bram_arb_pkg::*;
#(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_req_valid,
    output logic                      wr_req_ready,
    input  logic [RAM_ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [RAM_DATA_WIDTH-1:0] wr_req_data,
    input  logic                      rd_req_valid,
    output logic                      rd_req_ready,
    input  logic [RAM_ADDR_WIDTH-1:0] rd_req_addr,
    output logic                      rd_rsp_valid,
    input  logic                      rd_rsp_ready,
    output logic [RAM_DATA_WIDTH-1:0] rd_rsp_data,
    output logic                      ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_data_in,
    input  logic [RAM_DATA_WIDTH-1:0] ram_data_out
);
    logic [1:0] count, gnt;
    logic inflight, pop, rd_elig, wr_cand, rd_cand;
    assign rd_rsp_valid = ~rst & (count != 2'd0);
    assign pop = rd_rsp_valid & rd_rsp_ready;
    // A response leaving this cycle frees its slot immediately, which keeps
    // back-to-back reads at one per cycle when the consumer is always ready.
    assign rd_elig = ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'(RSP_DEPTH);
    assign wr_cand = ~rst & wr_req_valid;
    assign rd_cand = ~rst & rd_req_valid & rd_elig;
`ifdef BRAM_ARB_RR_EN
    logic last_rd;
    always_ff @(posedge clk) begin
        if (rst) last_rd <= 1'b1;
        else if (gnt != GNT_NONE) last_rd <= gnt == GNT_RD;
    end
    assign gnt = wr_cand && (!rd_cand || last_rd) ? GNT_WR : rd_cand ? GNT_RD : GNT_NONE;
`else
    assign gnt = wr_cand ? GNT_WR : rd_cand ? GNT_RD : GNT_NONE;
`endif
    assign wr_req_ready = gnt == GNT_WR;
    assign rd_req_ready = gnt == GNT_RD;
    assign ram_wr = gnt == GNT_WR;
    assign ram_addr = gnt == GNT_WR ? wr_req_addr : gnt == GNT_RD ? rd_req_addr : '0;
    assign ram_data_in = gnt == GNT_WR ? wr_req_data : '0;
    // ram_data_out carries the read issued last cycle while inflight is set.
    always_ff @(posedge clk) begin
        if (rst) inflight <= 1'b0;
        else inflight <= gnt == GNT_RD;
    end
    bram_rsp_buf #(.DW(RAM_DATA_WIDTH)) u_rsp_buf (
        .clk(clk),
        .rst(rst),
        .push(inflight),
        .push_data(ram_data_out),
        .pop(pop),
        .count(count),
        .head_data(rd_rsp_data)
    );
endmodule
